// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encodings and the bus
// widths common to the core, dmem and DMA master.
package dmem_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic {
        S_NORM  = 1'b0,
        S_FORCE = 1'b1
    } arb_state_t;

    // Width needed to hold the saturating DMA wait count 0..limit.
    function automatic int wait_cnt_w(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/dmem_starve_timer.sv
// Counts cycles a pending DMA request is refused and flags when the next
// count reaches the starvation limit, so the arbiter can steal one core cycle.
module dmem_starve_timer
    import dmem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int CW           = wait_cnt_w(STARVE_LIMIT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_dma_req,
    input  logic          i_dma_ack,
    input  logic          i_dma_grant,
    input  logic          i_clr,
    output logic          o_force_next,
    output logic [CW-1:0] o_wait_cnt
);

    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;

    always_comb begin
        w_cnt_next = r_cnt;
        if (!i_dma_req || i_dma_grant || i_clr) begin
            w_cnt_next = '0;
        end else if (!i_dma_ack) begin
            w_cnt_next = (r_cnt == LIMIT) ? LIMIT : r_cnt + 1'b1;
        end
    end

    // The forced cycle itself must never request another forced cycle.
    assign o_force_next = (w_cnt_next == LIMIT) && !i_clr;
    assign o_wait_cnt   = r_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port dmem arbiter: the core has same-cycle priority, DMA uses idle
// cycles, and a starvation timer forces one stalled core cycle for DMA.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = 8,
    parameter int CW           = wait_cnt_w(STARVE_LIMIT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wd,
    output logic [DATA_W-1:0] cpu_rd,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wd,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rd,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd,
    output arb_state_t        o_dbg_state,
    output logic [CW-1:0]     o_dbg_wait_cnt
);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    logic              r_ack;
    logic [DATA_W-1:0] r_rd;
    logic              w_grant;
    logic              w_force_next;
    logic              w_in_force;

    dmem_starve_timer #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CW           (CW)
    ) u_timer (
        .clk          (clk),
        .reset        (reset),
        .i_dma_req    (dma_req),
        .i_dma_ack    (r_ack),
        .i_dma_grant  (w_grant),
        .i_clr        (w_in_force),
        .o_force_next (w_force_next),
        .o_wait_cnt   (o_dbg_wait_cnt)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_NORM;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_NORM:  w_state_next = w_force_next ? S_FORCE : S_NORM;
            S_FORCE: w_state_next = S_NORM;
            default: w_state_next = S_NORM;
        endcase
    end

    // One-bubble turnaround: nothing is granted while the previous ack is out.
    always_comb begin
        w_in_force = (r_state == S_FORCE);
        cpu_stall  = w_in_force;
        w_grant    = dma_req && !r_ack && (w_in_force || !cpu_req);
    end

    always_comb begin
        if (w_grant) begin
            mem_we   = dma_we;
            mem_addr = dma_addr;
            mem_wd   = dma_wd;
        end else begin
            mem_we   = cpu_req && cpu_we;
            mem_addr = cpu_addr;
            mem_wd   = cpu_wd;
        end
        if (!reset) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ack <= 1'b0;
            r_rd  <= '0;
        end else begin
            r_ack <= w_grant;
            if (w_grant) begin
                r_rd <= mem_rd;
            end
        end
    end

    assign cpu_rd      = mem_rd;
    assign dma_ack     = r_ack;
    assign dma_rd      = r_rd;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations, then
// randomized core/DMA traffic checked every cycle against a transaction model.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LIM = 8;
    localparam int CW = wait_cnt_w(LIM);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wd = '0;
    logic [DW-1:0] cpu_rd;
    logic          cpu_stall;
    logic          dma_req = 1'b0, dma_we = 1'b0;
    logic [AW-1:0] dma_addr = '0;
    logic [DW-1:0] dma_wd = '0;
    logic          dma_ack;
    logic [DW-1:0] dma_rd;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;
    arb_state_t    dbg_state;
    logic [CW-1:0] dbg_wait_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
        .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wd(dma_wd),
        .dma_ack(dma_ack), .dma_rd(dma_rd),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .o_dbg_state(dbg_state), .o_dbg_wait_cnt(dbg_wait_cnt)
    );

    // Environment dmem: combinational read, write on posedge, driven by the DUT.
    logic [DW-1:0] env_mem [0:255];
    assign mem_rd = env_mem[mem_addr[9:2]];
    always @(posedge clk) if (mem_we) env_mem[mem_addr[9:2]] <= mem_wd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: who owns the memory each cycle, what it stores,
    // how long DMA has been refused, and what completion is owed next cycle.
    logic [DW-1:0] ref_mem [0:255];
    bit            m_valid = 0;
    bit            m_force = 0;
    int            m_waited = 0;
    bit            m_ack = 0;
    logic [DW-1:0] m_rd = '0;

    function automatic bit dma_wins();
        return dma_req && !m_ack && (m_force || !cpu_req);
    endfunction

    always @(posedge clk) begin
        bit            g;
        logic [DW-1:0] rd_now;
        int            w;
        g = dma_wins();
        if (!reset) begin
            m_valid = 1; m_force = 0; m_waited = 0; m_ack = 0; m_rd = '0;
        end else begin
            rd_now = ref_mem[dma_addr[9:2]];
            if (g && dma_we) ref_mem[dma_addr[9:2]] = dma_wd;
            else if (!g && cpu_req && cpu_we) ref_mem[cpu_addr[9:2]] = cpu_wd;
            w = m_waited;
            if (m_force || !dma_req || g) w = 0;
            else if (!m_ack) w = (w + 1 > LIM) ? LIM : w + 1;
            m_force  = !m_force && (w == LIM);
            m_waited = w;
            if (g) m_rd = rd_now;
            m_ack = g;
        end
    end

    always @(negedge clk) begin
        bit g;
        if (m_valid) begin
            g = dma_wins();
            check("mem_we", {31'b0, mem_we}, {31'b0, reset && (g ? dma_we : (cpu_req && cpu_we))});
            check("mem_addr", mem_addr, g ? dma_addr : cpu_addr);
            check("mem_wd", mem_wd, g ? dma_wd : cpu_wd);
            check("cpu_stall", {31'b0, cpu_stall}, {31'b0, m_force});
            check("dma_ack", {31'b0, dma_ack}, {31'b0, m_ack});
            if (m_ack) check("dma_rd", dma_rd, m_rd);
            check("cpu_rd", cpu_rd, ref_mem[(g ? dma_addr[9:2] : cpu_addr[9:2])]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        cpu_req = 0; cpu_we = 0; dma_req = 0; dma_we = 0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            env_mem[i] = '0;
            ref_mem[i] = '0;
        end

        // Reset held two cycles with both masters active: no memory write.
        reset = 0; dma_req = 1; dma_we = 1; dma_addr = 32'h40; dma_wd = 32'h11;
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h40; cpu_wd = 32'h22;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_mem_we", {31'b0, mem_we}, 32'd0);
            step();
        end
        reset = 1; idle_all();
        @(negedge clk);
        check("rst_dma_ack", {31'b0, dma_ack}, 32'd0);
        check("rst_cpu_stall", {31'b0, cpu_stall}, 32'd0);
        step();

        // DMA write while the core is idle: granted immediately.
        dma_req = 1; dma_we = 1; dma_addr = 32'h40; dma_wd = 32'hDEADBEEF;
        @(negedge clk);
        check("t2_grant_we", {31'b0, mem_we}, 32'd1);
        check("t2_grant_addr", mem_addr, 32'h40);
        step();
        @(negedge clk);
        check("t2_ack", {31'b0, dma_ack}, 32'd1);
        step();
        idle_all(); cpu_req = 1; cpu_addr = 32'h40;
        @(negedge clk);
        check("t2_core_load", cpu_rd, 32'hDEADBEEF);
        step();

        // DMA read with a held request: no second grant in the ack cycle.
        idle_all(); cpu_addr = 32'h80;
        dma_req = 1; dma_we = 0; dma_addr = 32'h40;
        @(negedge clk);
        check("t3_grant_addr", mem_addr, 32'h40);
        step();
        @(negedge clk);
        check("t3_ack", {31'b0, dma_ack}, 32'd1);
        check("t3_rd", dma_rd, 32'hDEADBEEF);
        check("t3_no_regrant", mem_addr, 32'h80);
        step();
        idle_all();
        step();

        // Core busy every cycle: exactly one forced stall 8 cycles after the request.
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20;
        dma_req = 1; dma_we = 1; dma_addr = 32'h44; dma_wd = 32'h55;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("t4_stall_c%0d", i), {31'b0, cpu_stall}, {31'b0, (i == 8)});
            check($sformatf("t4_ack_c%0d", i), {31'b0, dma_ack}, {31'b0, (i == 9)});
            if (i == 8) check("t4_force_addr", mem_addr, 32'h44);
            step();
            if (dma_ack) dma_req = 0;
        end
        idle_all();
        step();

        // Same-cycle core and DMA writes to one address: core first, DMA after.
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wd = 32'h1;
        dma_req = 1; dma_we = 1; dma_addr = 32'h10; dma_wd = 32'h2;
        step();
        cpu_req = 0; cpu_we = 0;
        @(negedge clk);
        check("t5_core_first", env_mem[4], 32'h1);
        step();
        @(negedge clk);
        check("t5_dma_ack", {31'b0, dma_ack}, 32'd1);
        check("t5_dma_second", env_mem[4], 32'h2);
        step();
        idle_all();
        step();

        // Reset at the edge that would deliver the ack: ack discarded.
        dma_req = 1; dma_we = 1; dma_addr = 32'h48; dma_wd = 32'h77;
        @(negedge clk);
        check("t6_grant", {31'b0, mem_we}, 32'd1);
        #1 reset = 0;
        step();
        reset = 1; dma_req = 0;
        @(negedge clk);
        check("t6_ack", {31'b0, dma_ack}, 32'd0);
        check("t6_state", {31'b0, dbg_state}, {31'b0, S_NORM});
        check("t6_wait", {28'b0, dbg_wait_cnt}, 32'd0);
        step();

        // Randomized traffic; DMA obeys hold-until-ack except for rare aborts.
        for (int c = 0; c < 3000; c++) begin
            if (dma_req && dma_ack) dma_req = 0;
            if (!dma_req) begin
                if ($urandom_range(0, 3) == 0) begin
                    dma_req = 1; dma_we = $urandom_range(0, 1) == 1;
                    dma_addr = 32'($urandom_range(0, 63)) << 2; dma_wd = $urandom;
                end
            end else if ($urandom_range(0, 60) == 0) begin
                dma_req = 0;
            end
            cpu_req  = $urandom_range(0, 9) < 8;
            cpu_we   = $urandom_range(0, 1) == 1;
            cpu_addr = 32'($urandom_range(0, 63)) << 2;
            cpu_wd   = $urandom;
            reset    = $urandom_range(0, 250) != 0;
            step();
        end
        reset = 1; idle_all();
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
